// File: rtl/jvm_bytecode_pkg.sv
// Shared definitions for the bytecode instruction assembler.
//   state_e      : assembler FSM states
//   OP_*         : opcode constants referenced by the length decode
//   op_supported : 1 when the opcode is implemented by the JIT path
//   op_len       : number of big-endian operand bytes following the opcode
package jvm_bytecode_pkg;

  typedef enum logic [2:0] {
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_e;

  localparam logic [7:0] OP_NOP          = 8'h00;
  localparam logic [7:0] OP_BIPUSH       = 8'h10;
  localparam logic [7:0] OP_SIPUSH       = 8'h11;
  localparam logic [7:0] OP_LDC          = 8'h12;
  localparam logic [7:0] OP_LDC_W        = 8'h13;
  localparam logic [7:0] OP_LDC2_W       = 8'h14;
  localparam logic [7:0] OP_ILOAD        = 8'h15;
  localparam logic [7:0] OP_ALOAD        = 8'h19;
  localparam logic [7:0] OP_ISTORE       = 8'h36;
  localparam logic [7:0] OP_ASTORE       = 8'h3A;
  localparam logic [7:0] OP_IINC         = 8'h84;
  localparam logic [7:0] OP_IFEQ         = 8'h99;
  localparam logic [7:0] OP_GOTO         = 8'hA7;
  localparam logic [7:0] OP_JSR          = 8'hA8;
  localparam logic [7:0] OP_RET          = 8'hA9;
  localparam logic [7:0] OP_TABLESWITCH  = 8'hAA;
  localparam logic [7:0] OP_LOOKUPSWITCH = 8'hAB;
  localparam logic [7:0] OP_GETSTATIC    = 8'hB2;
  localparam logic [7:0] OP_INVOKESTATIC = 8'hB8;
  localparam logic [7:0] OP_INVOKEINTF   = 8'hB9;
  localparam logic [7:0] OP_INVOKEDYN    = 8'hBA;
  localparam logic [7:0] OP_NEW          = 8'hBB;
  localparam logic [7:0] OP_NEWARRAY     = 8'hBC;
  localparam logic [7:0] OP_ANEWARRAY    = 8'hBD;
  localparam logic [7:0] OP_CHECKCAST    = 8'hC0;
  localparam logic [7:0] OP_INSTANCEOF   = 8'hC1;
  localparam logic [7:0] OP_WIDE         = 8'hC4;
  localparam logic [7:0] OP_MULTIANEWARR = 8'hC5;
  localparam logic [7:0] OP_IFNULL       = 8'hC6;
  localparam logic [7:0] OP_IFNONNULL    = 8'hC7;
  localparam logic [7:0] OP_GOTO_W       = 8'hC8;
  localparam logic [7:0] OP_JSR_W        = 8'hC9;
  localparam logic [7:0] OP_FIRST_RSVD   = 8'hCA;

  function automatic logic op_supported(input logic [7:0] op);
    return !(op inside {OP_TABLESWITCH, OP_LOOKUPSWITCH, OP_WIDE, [OP_FIRST_RSVD:8'hFF]});
  endfunction

  function automatic logic [2:0] op_len(input logic [7:0] op);
    logic [2:0] len;
    len = 3'd0;
    if (op inside {OP_BIPUSH, OP_LDC, [OP_ILOAD:OP_ALOAD], [OP_ISTORE:OP_ASTORE],
                   OP_RET, OP_NEWARRAY})
      len = 3'd1;
    else if (op inside {OP_SIPUSH, OP_LDC_W, OP_LDC2_W, OP_IINC, [OP_IFEQ:OP_JSR],
                        [OP_GETSTATIC:OP_INVOKESTATIC], OP_NEW, OP_ANEWARRAY,
                        OP_CHECKCAST, OP_INSTANCEOF, OP_IFNULL, OP_IFNONNULL})
      len = 3'd2;
    else if (op == OP_MULTIANEWARR)
      len = 3'd3;
    else if (op inside {OP_INVOKEINTF, OP_INVOKEDYN, OP_GOTO_W, OP_JSR_W})
      len = 3'd4;
    return len;
  endfunction

endpackage

// File: rtl/bytecode_instr_assembler.sv
// Bytecode instruction assembler: consumer side of the next_byte_gen fetch
// protocol. Requests one byte at a time, groups opcode + operand bytes into a
// complete JVM instruction and hands it to the JIT stage on a valid/ack pair.
//   clk, reset_n                 : clock, asynchronous active-low reset
//   fetch_start                  : one-cycle byte request
//   fetch_ready / fetch_byte     : returned byte, valid for one cycle
//   fetch_pc_reset(_value)       : active-low one-cycle PC load to the fetcher
//   redirect / redirect_pc       : branch/flush to a new bytecode PC
//   instr_valid / instr_ack      : instruction handshake
//   instr_opcode/operand/len/pc  : assembled instruction
//   instr_illegal                : opcode not supported; assembler halts after ack
// All outputs are registered.
module bytecode_instr_assembler
  import jvm_bytecode_pkg::*;
#(
  parameter int unsigned                  ADDRESS_WIDTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0]     RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     fetch_start,
  input  logic                     fetch_ready,
  input  logic [7:0]               fetch_byte,
  output logic                     fetch_pc_reset,
  output logic [ADDRESS_WIDTH-1:0] fetch_pc_reset_value,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ack,
  output logic [7:0]               instr_opcode,
  output logic [31:0]              instr_operand,
  output logic [2:0]               instr_len,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     instr_illegal
);

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic                     outstanding_q;
  logic                     stale_q;
  logic                     have_op_q;
  logic [2:0]               remaining_q;

  logic                     fetch_start_q;
  logic                     fetch_pc_reset_q;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_reset_value_q;
  logic                     instr_valid_q;
  logic [7:0]               instr_opcode_q;
  logic [31:0]              instr_operand_q;
  logic [2:0]               instr_len_q;
  logic [ADDRESS_WIDTH-1:0] instr_pc_q;
  logic                     instr_illegal_q;

  logic                     take_byte;

  // A returned byte is ours only if no stale response is still pending.
  assign take_byte = fetch_ready && !stale_q;

  // Outputs are decoded from the state being entered, so fetch_start and
  // instr_valid are high exactly during the S_REQ / S_HOLD cycles. S_LOAD is
  // entered with fetch_pc_reset already high after reset, so it first spends
  // one cycle issuing the PC load before moving on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q                <= S_LOAD;
      pc_q                   <= RESET_PC;
      outstanding_q          <= 1'b0;
      stale_q                <= 1'b0;
      have_op_q              <= 1'b0;
      remaining_q            <= '0;
      fetch_start_q          <= 1'b0;
      fetch_pc_reset_q       <= 1'b1;
      fetch_pc_reset_value_q <= RESET_PC;
      instr_valid_q          <= 1'b0;
      instr_opcode_q         <= '0;
      instr_operand_q        <= '0;
      instr_len_q            <= '0;
      instr_pc_q             <= RESET_PC;
      instr_illegal_q        <= 1'b0;
    end else begin
      fetch_start_q    <= 1'b0;
      fetch_pc_reset_q <= 1'b1;
      if (fetch_ready && stale_q)
        stale_q <= 1'b0;

      if (redirect) begin
        pc_q                   <= redirect_pc;
        state_q                <= S_LOAD;
        fetch_pc_reset_q       <= 1'b0;
        fetch_pc_reset_value_q <= redirect_pc;
        instr_valid_q          <= 1'b0;
        instr_illegal_q        <= 1'b0;
        have_op_q              <= 1'b0;
        remaining_q            <= '0;
        instr_operand_q        <= '0;
        outstanding_q          <= 1'b0;
        // A request still in flight will answer later; remember to drop it,
        // unless its answer is the byte arriving right now.
        stale_q <= (outstanding_q && !take_byte) || (stale_q && !fetch_ready);
      end else begin
        case (state_q)
          S_LOAD: begin
            have_op_q       <= 1'b0;
            remaining_q     <= '0;
            instr_operand_q <= '0;
            if (fetch_pc_reset_q) begin
              fetch_pc_reset_q       <= 1'b0;
              fetch_pc_reset_value_q <= pc_q;
            end else begin
              state_q       <= S_REQ;
              fetch_start_q <= 1'b1;
              outstanding_q <= 1'b1;
            end
          end

          S_REQ: begin
            state_q <= S_WAIT;
          end

          S_WAIT: begin
            if (take_byte) begin
              outstanding_q <= 1'b0;
              if (!have_op_q) begin
                have_op_q       <= 1'b1;
                instr_opcode_q  <= fetch_byte;
                instr_operand_q <= '0;
                instr_pc_q      <= pc_q;
                if (!op_supported(fetch_byte)) begin
                  instr_illegal_q <= 1'b1;
                  instr_len_q     <= '0;
                  remaining_q     <= '0;
                  state_q         <= S_HOLD;
                  instr_valid_q   <= 1'b1;
                end else begin
                  instr_illegal_q <= 1'b0;
                  instr_len_q     <= op_len(fetch_byte);
                  remaining_q     <= op_len(fetch_byte);
                  if (op_len(fetch_byte) == 3'd0) begin
                    state_q       <= S_HOLD;
                    instr_valid_q <= 1'b1;
                  end else begin
                    state_q       <= S_REQ;
                    fetch_start_q <= 1'b1;
                    outstanding_q <= 1'b1;
                  end
                end
              end else begin
                instr_operand_q <= {instr_operand_q[23:0], fetch_byte};
                remaining_q     <= remaining_q - 3'd1;
                if (remaining_q == 3'd1) begin
                  state_q       <= S_HOLD;
                  instr_valid_q <= 1'b1;
                end else begin
                  state_q       <= S_REQ;
                  fetch_start_q <= 1'b1;
                  outstanding_q <= 1'b1;
                end
              end
            end
          end

          S_HOLD: begin
            if (instr_ack) begin
              instr_valid_q <= 1'b0;
              have_op_q     <= 1'b0;
              if (instr_illegal_q) begin
                state_q <= S_HALT;
              end else begin
                pc_q          <= pc_q + ADDRESS_WIDTH'(instr_len_q) + ADDRESS_WIDTH'(1);
                state_q       <= S_REQ;
                fetch_start_q <= 1'b1;
                outstanding_q <= 1'b1;
              end
            end
          end

          S_HALT: begin
            state_q <= S_HALT;
          end

          default: begin
            state_q <= S_LOAD;
          end
        endcase
      end
    end
  end

  assign fetch_start          = fetch_start_q;
  assign fetch_pc_reset       = fetch_pc_reset_q;
  assign fetch_pc_reset_value = fetch_pc_reset_value_q;
  assign instr_valid          = instr_valid_q;
  assign instr_opcode         = instr_opcode_q;
  assign instr_operand        = instr_operand_q;
  assign instr_len            = instr_len_q;
  assign instr_pc             = instr_pc_q;
  assign instr_illegal        = instr_illegal_q;

endmodule

// File: tb/tb_bytecode_instr_assembler.sv
// Directed bench for bytecode_instr_assembler with a behavioural byte fetcher
// (programmable latency, in-order responses, PC load on fetch_pc_reset).
module tb_bytecode_instr_assembler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_start;
  logic        fetch_ready;
  logic [7:0]  fetch_byte;
  logic        fetch_pc_reset;
  logic [7:0]  fetch_pc_reset_value;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ack;
  logic [7:0]  instr_opcode;
  logic [31:0] instr_operand;
  logic [2:0]  instr_len;
  logic [7:0]  instr_pc;
  logic        instr_illegal;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];
  int         lat = 1;
  int         fs_count = 0;

  typedef struct {
    int         due;
    logic [7:0] addr;
  } req_t;
  req_t pend[$];

  always #5 clk = ~clk;

  bytecode_instr_assembler #(.ADDRESS_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .fetch_start          (fetch_start),
    .fetch_ready          (fetch_ready),
    .fetch_byte           (fetch_byte),
    .fetch_pc_reset       (fetch_pc_reset),
    .fetch_pc_reset_value (fetch_pc_reset_value),
    .redirect             (redirect),
    .redirect_pc          (redirect_pc),
    .instr_valid          (instr_valid),
    .instr_ack            (instr_ack),
    .instr_opcode         (instr_opcode),
    .instr_operand        (instr_operand),
    .instr_len            (instr_len),
    .instr_pc             (instr_pc),
    .instr_illegal        (instr_illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!instr_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic ack_pulse();
    instr_ack = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0;
  endtask

  task automatic redirect_pulse(input logic [7:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    redirect    = 1'b0;
  endtask

  // Behavioural fetcher: samples controls mid-cycle, responds after the edge.
  initial begin
    logic       fs, pr;
    logic [7:0] prv, fpc;
    int         fcyc;
    fetch_ready = 1'b0;
    fetch_byte  = 8'h00;
    fpc         = 8'h00;
    fcyc        = 0;
    forever begin
      @(negedge clk);
      fs  = fetch_start;
      pr  = fetch_pc_reset;
      prv = fetch_pc_reset_value;
      @(posedge clk);
      #1;
      fcyc++;
      fetch_ready = 1'b0;
      if (!reset_n) begin
        pend.delete();
        continue;
      end
      if (!pr) fpc = prv;
      if (fs) begin
        pend.push_back('{due: fcyc + lat - 1, addr: fpc});
        fpc = fpc + 8'd1;
        fs_count++;
      end
      if (pend.size() > 0 && pend[0].due <= fcyc) begin
        fetch_ready = 1'b1;
        fetch_byte  = mem[pend[0].addr];
        void'(pend.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int snap;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h01; mem[8'h02] = 8'h2C;
    reset_n     = 1'b0;
    instr_ack   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_fetch_start", 32'(fetch_start), 32'd0);
    check_eq("rst_pc_reset", 32'(fetch_pc_reset), 32'd1);
    check_eq("rst_pc_reset_value", 32'(fetch_pc_reset_value), 32'h00);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_opcode", 32'(instr_opcode), 32'h00);
    check_eq("rst_operand", instr_operand, 32'h0);
    check_eq("rst_len", 32'(instr_len), 32'd0);
    check_eq("rst_pc", 32'(instr_pc), 32'h00);
    check_eq("rst_illegal", 32'(instr_illegal), 32'd0);

    // Startup: PC load pulse, then the first request
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("start_pc_reset_low", 32'(fetch_pc_reset), 32'd0);
    check_eq("start_pc_reset_value", 32'(fetch_pc_reset_value), 32'h00);
    check_eq("start_no_fetch_yet", 32'(fetch_start), 32'd0);
    @(negedge clk);
    check_eq("start_pc_reset_high", 32'(fetch_pc_reset), 32'd1);
    check_eq("start_first_fetch", 32'(fetch_start), 32'd1);

    // sipush 300: 2 operands -> valid 6 cycles after first fetch_start
    n = 0;
    while (!instr_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("sipush_latency", n, 6);
    check_eq("sipush_opcode", 32'(instr_opcode), 32'h11);
    check_eq("sipush_operand", instr_operand, 32'h0000012C);
    check_eq("sipush_len", 32'(instr_len), 32'd2);
    check_eq("sipush_pc", 32'(instr_pc), 32'h00);
    check_eq("sipush_illegal", 32'(instr_illegal), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_no_fetch", 32'(fetch_start), 32'd0);
      check_eq("hold_valid", 32'(instr_valid), 32'd1);
    end
    check_eq("hold_operand_stable", instr_operand, 32'h0000012C);
    ack_pulse();
    check_eq("sipush_ack_valid_drop", 32'(instr_valid), 32'd0);
    check_eq("sipush_ack_next_fetch", 32'(fetch_start), 32'd1);

    // Reset mid-instruction, then iconst_1 / iadd back to back
    reset_n = 1'b0;
    mem[8'h00] = 8'h04; mem[8'h01] = 8'h60; mem[8'h02] = 8'hA7;
    mem[8'h03] = 8'h00; mem[8'h04] = 8'h00;
    @(negedge clk);
    check_eq("midrst_fetch_start", 32'(fetch_start), 32'd0);
    check_eq("midrst_valid", 32'(instr_valid), 32'd0);
    reset_n = 1'b1;
    wait_valid("iconst1");
    check_eq("iconst1_opcode", 32'(instr_opcode), 32'h04);
    check_eq("iconst1_pc", 32'(instr_pc), 32'h00);
    check_eq("iconst1_len", 32'(instr_len), 32'd0);
    ack_pulse();
    check_eq("iconst1_b2b_fetch", 32'(fetch_start), 32'd1);
    wait_valid("iadd");
    check_eq("iadd_opcode", 32'(instr_opcode), 32'h60);
    check_eq("iadd_pc", 32'(instr_pc), 32'h01);
    check_eq("iadd_len", 32'(instr_len), 32'd0);

    // goto at 0x02 with slow fetcher; redirect while operand byte in flight
    lat = 4;
    mem[8'h40] = 8'h10; mem[8'h41] = 8'h85;
    ack_pulse();
    check_eq("goto_opcode_fetch", 32'(fetch_start), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fetch_start && n < 40);
    check_eq("goto_operand_fetch", 32'(fetch_start), 32'd1);
    @(negedge clk);
    redirect_pulse(8'h40);
    check_eq("redir_pc_reset_low", 32'(fetch_pc_reset), 32'd0);
    check_eq("redir_pc_reset_value", 32'(fetch_pc_reset_value), 32'h40);
    check_eq("redir_valid_low", 32'(instr_valid), 32'd0);
    wait_valid("bipush");
    check_eq("bipush_opcode", 32'(instr_opcode), 32'h10);
    check_eq("bipush_operand", instr_operand, 32'h00000085);
    check_eq("bipush_len", 32'(instr_len), 32'd1);
    check_eq("bipush_pc", 32'(instr_pc), 32'h40);

    // Unsupported opcode at 0x42 halts the assembler
    lat = 1;
    mem[8'h42] = 8'hAA;
    mem[8'h10] = 8'h00;
    ack_pulse();
    wait_valid("tableswitch");
    check_eq("tswitch_illegal", 32'(instr_illegal), 32'd1);
    check_eq("tswitch_len", 32'(instr_len), 32'd0);
    check_eq("tswitch_opcode", 32'(instr_opcode), 32'hAA);
    check_eq("tswitch_pc", 32'(instr_pc), 32'h42);
    ack_pulse();
    snap = fs_count;
    repeat (20) @(negedge clk);
    check_eq("halt_no_fetch", fs_count - snap, 0);
    check_eq("halt_valid_low", 32'(instr_valid), 32'd0);
    redirect_pulse(8'h10);
    check_eq("resume_pc_reset_value", 32'(fetch_pc_reset_value), 32'h10);
    wait_valid("nop");
    check_eq("nop_opcode", 32'(instr_opcode), 32'h00);
    check_eq("nop_pc", 32'(instr_pc), 32'h10);
    check_eq("nop_illegal", 32'(instr_illegal), 32'd0);

    // goto_w at 0xFE: operands wrap through 0x00..0x02, next PC is 0x03
    mem[8'hFE] = 8'hC8; mem[8'hFF] = 8'h12; mem[8'h00] = 8'h34;
    mem[8'h01] = 8'h56; mem[8'h02] = 8'h78; mem[8'h03] = 8'hB1;
    mem[8'h11] = 8'h00; mem[8'h20] = 8'h05;
    ack_pulse();
    redirect_pulse(8'hFE);
    wait_valid("goto_w");
    check_eq("gotow_opcode", 32'(instr_opcode), 32'hC8);
    check_eq("gotow_operand", instr_operand, 32'h12345678);
    check_eq("gotow_len", 32'(instr_len), 32'd4);
    check_eq("gotow_pc", 32'(instr_pc), 32'hFE);
    ack_pulse();
    wait_valid("return");
    check_eq("return_opcode", 32'(instr_opcode), 32'hB1);
    check_eq("return_pc_wrap", 32'(instr_pc), 32'h03);

    // Redirect and ack in the same cycle: redirect wins
    instr_ack = 1'b1;
    redirect_pulse(8'h20);
    instr_ack = 1'b0;
    check_eq("both_pc_reset_low", 32'(fetch_pc_reset), 32'd0);
    check_eq("both_pc_reset_value", 32'(fetch_pc_reset_value), 32'h20);
    check_eq("both_valid_low", 32'(instr_valid), 32'd0);
    wait_valid("iconst2");
    check_eq("iconst2_opcode", 32'(instr_opcode), 32'h05);
    check_eq("iconst2_pc", 32'(instr_pc), 32'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
